// File: rtl/simple_fifo_flagged_pkg.sv
// Shared FIFO helpers: address/count width derivation reused across FIFO blocks.
package simple_fifo_flagged_pkg;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = v - 1;
        for (int i = 0; i < 32; i++) begin
            if (x != 0) begin
                r = r + 1;
                x = x >> 1;
            end
        end
        return r;
    endfunction

    // Count must represent 0..DEPTH inclusive, hence one bit wider than the pointer.
    function automatic int unsigned count_width(input int unsigned depth);
        return clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/simple_fifo_mem.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port, no reset.
module simple_fifo_mem
    import simple_fifo_flagged_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [clog2(DEPTH)-1:0]  waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [clog2(DEPTH)-1:0]  raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/simple_fifo_flagged.sv
// Single-clock FIFO with occupancy flags, sticky overflow/underflow and selectable
// registered-read or first-word-fall-through output.
module simple_fifo_flagged
    import simple_fifo_flagged_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned FWFT      = 0,
    parameter int unsigned AFULL_TH  = DEPTH - 2,
    parameter int unsigned AEMPTY_TH = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          we,
    input  logic [WIDTH-1:0]              din,
    input  logic                          re,
    output logic [WIDTH-1:0]              dout,
    output logic                          valid,
    output logic                          empty,
    output logic                          full,
    output logic                          almost_empty,
    output logic                          almost_full,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned CW = count_width(DEPTH);

    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    cnt_nxt;
    logic             wr_acc;
    logic             rd_acc;
    logic [WIDTH-1:0] rd_data;

    assign wr_acc = we && !full && !clear;
    assign rd_acc = re && !empty && !clear;

    simple_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wptr),
        .wdata (din),
        .raddr (rptr),
        .rdata (rd_data)
    );

    always_comb begin
        cnt_nxt = count;
        if (clear) begin
            cnt_nxt = '0;
        end else if (wr_acc && !rd_acc) begin
            cnt_nxt = count + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            cnt_nxt = count - CW'(1);
        end
    end

    // Flags are registered alongside count so they always agree with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (clear) begin
                wptr      <= '0;
                rptr      <= '0;
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end else begin
                if (wr_acc) begin
                    wptr <= wptr + AW'(1);
                end
                if (rd_acc) begin
                    rptr <= rptr + AW'(1);
                end
                if (we && full) begin
                    overflow <= 1'b1;
                end
                if (re && empty) begin
                    underflow <= 1'b1;
                end
            end
            count        <= cnt_nxt;
            empty        <= (cnt_nxt == '0);
            full         <= (cnt_nxt == CW'(DEPTH));
            almost_full  <= (cnt_nxt >= CW'(AFULL_TH));
            almost_empty <= (cnt_nxt <= CW'(AEMPTY_TH));
        end
    end

    generate
        if (FWFT == 0) begin : g_reg_read
            logic [WIDTH-1:0] dout_q;
            logic             valid_q;

            // Popped word is captured; dout holds between pops and across clear.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    dout_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= rd_acc;
                    if (rd_acc) begin
                        dout_q <= rd_data;
                    end
                end
            end

            assign dout  = dout_q;
            assign valid = valid_q;
        end else begin : g_fwft
            assign dout  = rd_data;
            assign valid = !empty;
        end
    endgenerate

endmodule

// File: tb/tb_simple_fifo_flagged.sv
// Self-checking bench: registered-read and FWFT instances share stimulus and are
// compared against a queue-based reference model.
module tb_simple_fifo_flagged;

    localparam int unsigned W  = 8;
    localparam int unsigned D  = 8;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          clear;
    logic          we;
    logic [W-1:0]  din;
    logic          re;

    logic [W-1:0]  dout0, dout1;
    logic          valid0, valid1;
    logic          empty0, empty1, full0, full1;
    logic          ae0, ae1, af0, af1;
    logic [CW-1:0] count0, count1;
    logic          ovf0, ovf1, unf0, unf1;

    int checks   = 0;
    int failures = 0;
    string phase = "reset";

    logic [W-1:0] q[$];
    logic         m_ovf, m_unf, m_valid0;
    logic [W-1:0] m_dout0;

    always #5 clk = ~clk;

    simple_fifo_flagged #(.WIDTH(W), .DEPTH(D), .FWFT(0), .AFULL_TH(6), .AEMPTY_TH(1)) u_reg (
        .clk(clk), .reset(reset), .clear(clear), .we(we), .din(din), .re(re),
        .dout(dout0), .valid(valid0), .empty(empty0), .full(full0),
        .almost_empty(ae0), .almost_full(af0), .count(count0),
        .overflow(ovf0), .underflow(unf0)
    );

    simple_fifo_flagged #(.WIDTH(W), .DEPTH(D), .FWFT(1), .AFULL_TH(6), .AEMPTY_TH(1)) u_fwft (
        .clk(clk), .reset(reset), .clear(clear), .we(we), .din(din), .re(re),
        .dout(dout1), .valid(valid1), .empty(empty1), .full(full1),
        .almost_empty(ae1), .almost_full(af1), .count(count1),
        .overflow(ovf1), .underflow(unf1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s:%s observed=%0h expected=%0h", phase, tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf    = 1'b0;
        m_unf    = 1'b0;
        m_valid0 = 1'b0;
        m_dout0  = '0;
    endtask

    task automatic model_step(input logic w, input logic [W-1:0] d, input logic r, input logic c);
        int sz;
        sz = q.size();
        if (c) begin
            q.delete();
            m_ovf    = 1'b0;
            m_unf    = 1'b0;
            m_valid0 = 1'b0;
        end else begin
            if (w && sz == D) m_ovf = 1'b1;
            if (r && sz == 0) m_unf = 1'b1;
            m_valid0 = 1'b0;
            if (r && sz > 0) begin
                m_dout0  = q.pop_front();
                m_valid0 = 1'b1;
            end
            if (w && sz < D) q.push_back(d);
        end
    endtask

    task automatic check_all();
        int sz;
        sz = q.size();
        chk("count0", 32'(count0), 32'(sz));
        chk("count1", 32'(count1), 32'(sz));
        chk("empty0", 32'(empty0), 32'(sz == 0));
        chk("empty1", 32'(empty1), 32'(sz == 0));
        chk("full0",  32'(full0),  32'(sz == D));
        chk("full1",  32'(full1),  32'(sz == D));
        chk("af0",    32'(af0),    32'(sz >= 6));
        chk("ae0",    32'(ae0),    32'(sz <= 1));
        chk("af1",    32'(af1),    32'(sz >= 6));
        chk("ae1",    32'(ae1),    32'(sz <= 1));
        chk("ovf0",   32'(ovf0),   32'(m_ovf));
        chk("unf0",   32'(unf0),   32'(m_unf));
        chk("ovf1",   32'(ovf1),   32'(m_ovf));
        chk("unf1",   32'(unf1),   32'(m_unf));
        chk("valid0", 32'(valid0), 32'(m_valid0));
        chk("dout0",  32'(dout0),  32'(m_dout0));
        chk("valid1", 32'(valid1), 32'(sz > 0));
        if (sz > 0) chk("dout1", 32'(dout1), 32'(q[0]));
    endtask

    // One clock: drive at negedge, let the edge happen, update model, check at next negedge.
    task automatic cyc(input logic w, input logic [W-1:0] d, input logic r, input logic c);
        we = w; din = d; re = r; clear = c;
        @(posedge clk);
        model_step(w, d, r, c);
        @(negedge clk);
        we = 1'b0; re = 1'b0; clear = 1'b0;
        check_all();
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; we = 1'b0; re = 1'b0; din = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        reset = 1'b0;
        @(negedge clk);
        check_all();

        phase = "fill_drain";
        for (int i = 0; i < 8; i++) cyc(1'b1, W'(8'h11 + i), 1'b0, 1'b0);
        chk("full_after_8", 32'(full0), 32'd1);
        for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        chk("last_pop", 32'(dout0), 32'h18);
        cyc(1'b0, '0, 1'b0, 1'b0);

        phase = "fwft_single";
        cyc(1'b1, 8'hA5, 1'b0, 1'b0);
        chk("fwft_head", 32'(dout1), 32'hA5);
        cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("fwft_empty", 32'(empty1), 32'd1);

        phase = "overflow";
        for (int i = 0; i < 8; i++) cyc(1'b1, W'(8'h30 + i), 1'b0, 1'b0);
        cyc(1'b1, 8'h99, 1'b0, 1'b0);
        cyc(1'b1, 8'h99, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        phase = "underflow";
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1);

        phase = "stream";
        for (int i = 0; i < 4; i++) cyc(1'b1, W'(8'h40 + i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b1, W'(8'h44 + i), 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1);

        phase = "clear_prio";
        for (int i = 0; i < 8; i++) cyc(1'b1, W'(8'h60 + i), 1'b0, 1'b0);
        cyc(1'b1, 8'h77, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        chk("pre_clear_cnt", 32'(count0), 32'd5);
        cyc(1'b1, 8'hEE, 1'b1, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b0);

        phase = "async_reset";
        for (int i = 0; i < 3; i++) cyc(1'b1, W'(8'h80 + i), 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_all();

        phase = "random";
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 99) < 55), W'($urandom), 1'($urandom_range(0, 99) < 45),
                1'($urandom_range(0, 99) < 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/simple_fifo_flagged.md
SIMPLE_FIFO_FLAGGED -- requirements
Module: simple_fifo_flagged

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width in bits, >= 1.
REQ-002 SHALL have parameter DEPTH, default 8: entry count, power of two, >= 2.
REQ-003 SHALL have parameter FWFT, default 0: 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-004 SHALL have parameter AFULL_TH, default DEPTH-2: almost_full threshold, 1..DEPTH.
REQ-005 SHALL have parameter AEMPTY_TH, default 1: almost_empty threshold, 0..DEPTH-1.
REQ-006 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-007 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port clear, input, 1: synchronous flush.
REQ-009 SHALL have port we, input, 1: write request.
REQ-010 SHALL have port din, input, WIDTH: write data.
REQ-011 SHALL have port re, input, 1: read request (pop).
REQ-012 SHALL have port dout, output, WIDTH: read data.
REQ-013 SHALL have port valid, output, 1: dout holds freshly popped data (FWFT=0), or dout holds head entry (FWFT=1).
REQ-014 SHALL have ports empty, full, almost_empty, almost_full, each output, 1: occupancy flags.
REQ-015 SHALL have port count, output, clog2(DEPTH)+1: current occupancy, 0..DEPTH.
REQ-016 SHALL have ports overflow, underflow, each output, 1: sticky error flags.

Function
REQ-017 SHALL accept a write on a clk edge iff we=1, full=0 and clear=0; din is stored at the write pointer.
REQ-018 SHALL accept a read on a clk edge iff re=1, empty=0 and clear=0; the read pointer advances.
REQ-019 SHALL, on simultaneous accepted write and read, leave count unchanged; writes while full are never accepted, even when re=1.
REQ-020 SHALL wrap both pointers modulo DEPTH with no bubble.
REQ-021 SHALL increment count by 1 per accepted write, decrement by 1 per accepted read, net 0 for both.
REQ-022 SHALL drive empty = (count==0), full = (count==DEPTH), almost_full = (count>=AFULL_TH), almost_empty = (count<=AEMPTY_TH), all decoded from registered count.
REQ-023 SHALL, when FWFT=0, register the popped entry into dout and assert valid for exactly the one cycle after an accepted read; dout otherwise holds its last value.
REQ-024 SHALL, when FWFT=1, drive dout combinationally from the head entry with valid = !empty; an accepted read exposes the next entry in the following cycle.
REQ-025 SHALL set overflow on any edge with we=1, full=1, clear=0; the write data is dropped.
REQ-026 SHALL set underflow on any edge with re=1, empty=1, clear=0; pointers are unchanged.
REQ-027 SHALL keep overflow and underflow set until reset or clear.
REQ-028 SHALL give clear priority over we and re: pointers, count, overflow, underflow and valid go to 0 next edge; dout is held; memory contents are not erased.

Reset
REQ-029 SHALL, while reset=1, immediately force pointers=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, valid=0, overflow=0, underflow=0, dout=0 (FWFT=0).
REQ-030 SHALL discard all in-flight operations when reset asserts mid-transfer; the storage array is not reset.

Structure
REQ-031 SHALL place the clog2 constant function and the count-width derivation in the shared FIFO include, for reuse by other FIFO blocks.
REQ-032 SHALL instantiate one sub-module simple_fifo_mem (DEPTH x WIDTH array, one synchronous write port, one asynchronous read port); pointer, count, flag and mode logic stays in the top level.

Verification (WIDTH=8, DEPTH=8, AFULL_TH=6, AEMPTY_TH=1)
REQ-033 SHALL cover: FWFT=0, write 0x11..0x18 -> full=1 and count=8 after 8th edge; almost_full from count=6; then 8 reads -> dout 0x11..0x18 in order, each with 1-cycle valid, then empty=1.
REQ-034 SHALL cover: FWFT=1, write 0xA5 into an empty FIFO -> next cycle valid=1 and dout=0xA5 with no re; re=1 for one cycle -> empty=1 next cycle.
REQ-035 SHALL cover: FIFO full, we=1 with din=0x99 -> overflow=1, count stays 8, and 0x99 never appears; FIFO empty, re=1 -> underflow=1.
REQ-036 SHALL cover: count=4, we=re=1 for 20 cycles with an incrementing pattern -> count stays 4, pointers wrap, data order preserved.
REQ-037 SHALL cover: count=5 with overflow=1, clear=1 plus we=1 -> next cycle count=0, empty=1, overflow=0, write ignored.
REQ-038 SHALL cover: reset asserted asynchronously between edges at count=3 -> flags and count reach reset values before the next clk edge.
